// File: rtl/bcd_pkg.sv
// Shared BCD display codes and converter state encoding.
// bcd_to_7seg decodes the same two display codes.
package bcd_pkg;

  localparam logic [3:0] BCD_MINUS = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } conv_state_e;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a producer and the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg;

  // Producer side: issues requests, observes results.
  modport master (output start, output bin_in,
                  input  busy,  input  done, input bcd_out, input neg);

  // Converter side.
  modport slave  (input  start, input  bin_in,
                  output busy,  output done, output bcd_out, output neg);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Conditional +3 correction.
  always_comb begin
    d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential signed-binary to packed-BCD converter (one bit per clock).
// Optionally blanks leading zeros and places a minus code for bcd_to_7seg.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  conv_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  fmt;
  logic              lz_run;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scratch_q[4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  // Leading-zero blanking and minus placement on the finished digits.
  always_comb begin
    fmt    = scratch_q;
    lz_run = 1'b1;
    if (BLANK_LZ != 0) begin
      // Digit 0 is never blanked so that zero still shows as "0".
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lz_run && (scratch_q[4*i +: 4] == 4'd0)) begin
          fmt[4*i +: 4] = BCD_BLANK;
        end else begin
          lz_run = 1'b0;
        end
      end
      // Minus goes in the blank directly left of the leading significant digit.
      if (sign_q) begin
        for (int i = DIGITS - 1; i >= 1; i--) begin
          if ((fmt[4*i +: 4] == BCD_BLANK) && (fmt[4*(i-1) +: 4] != BCD_BLANK)) begin
            fmt[4*i +: 4] = BCD_MINUS;
          end
        end
      end
    end
  end

  // FSM next-state, datapath next-state and result update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Two's-complement negate; the most negative value wraps to 2^(WIDTH-1),
          // which is exactly its magnitude as an unsigned number.
          mag_d     = bus.bin_in[WIDTH-1] ? (~bus.bin_in + 1'b1) : bus.bin_in;
          sign_d    = bus.bin_in[WIDTH-1];
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, mag_d} = {adj, mag_q} << 1;
        cnt_d              = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        bcd_d   = fmt;
        neg_d   = sign_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= {DIGITS{BCD_BLANK}};
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  // Shift datapath; always cleared on acceptance, so it needs no reset.
  always_ff @(posedge clk) begin
    mag_q     <= mag_d;
    scratch_q <= scratch_d;
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.neg     = neg_q;

endmodule
